// File: rtl/data_memory_arbiter_pkg.sv
// Shared encodings for the data memory write scheduler: op codes, FSM states, register count.
`ifndef DATA_MEMORY_ARBITER_PKG_SV
`define DATA_MEMORY_ARBITER_PKG_SV
package data_memory_arbiter_pkg;

  localparam int unsigned NUM_REGS = 4;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_XOR   = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage
`endif

// File: rtl/data_memory_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module data_memory_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_valid_c
);

  logic [IDX_W:0] w_pos;

  // Scan from farthest to nearest so the candidate closest to the pointer wins.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_pos     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = (IDX_W+1)'(i_ptr) + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (i_req[w_pos[IDX_W-1:0]]) begin
        o_grant_c                    = '0;
        o_grant_c[w_pos[IDX_W-1:0]]  = 1'b1;
        o_idx_c                      = w_pos[IDX_W-1:0];
        o_valid_c                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin write scheduler owning the register file's write_id/new_data; zero-fills the
// file after reset and supports WRITE/ADD/SUB/XOR read-modify-write transactions.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  input  logic [NUM_REQ*2-1:0]      req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0]         reg1,
  input  logic [DATA_W-1:0]         reg2,
  input  logic [DATA_W-1:0]         reg3,
  input  logic [DATA_W-1:0]         reg4,
  output logic [ID_W-1:0]           write_id,
  output logic [DATA_W-1:0]         new_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  state_e              r_state;
  logic [ID_W-1:0]     r_cnt;
  logic [PTR_W-1:0]    r_ptr;
  logic [ID_W-1:0]     r_write_id;
  logic [DATA_W-1:0]   r_new_data;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]    w_idx;
  logic                w_valid;
  logic [ID_W-1:0]     w_id;
  op_e                 w_op;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W-1:0]   w_cur;
  logic [DATA_W-1:0]   w_result;
  logic [PTR_W-1:0]    w_ptr_nxt;

  assign write_id = r_write_id;
  assign new_data = r_new_data;
  assign ack      = r_ack;
  assign busy     = r_busy;

  data_memory_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (PTR_W)
  ) u_rr (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_valid_c (w_valid)
  );

  // Route the granted requester's slice.
  always_comb begin
    w_id   = '0;
    w_op   = OP_WRITE;
    w_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_idx == PTR_W'(k)) begin
        w_id   = req_id[k*ID_W +: ID_W];
        w_op   = op_e'(req_op[k*2 +: 2]);
        w_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Current contents of the target register; the file commits on the falling edge,
  // so a back-to-back RMW already sees the previous result here.
  always_comb begin
    w_cur = reg4;
    case (w_id)
      ID_W'(0): w_cur = reg1;
      ID_W'(1): w_cur = reg2;
      ID_W'(2): w_cur = reg3;
      default:  w_cur = reg4;
    endcase
  end

  always_comb begin
    w_result = w_data;
    case (w_op)
      OP_WRITE: w_result = w_data;
      OP_ADD:   w_result = w_cur + w_data;
      OP_SUB:   w_result = w_cur - w_data;
      OP_XOR:   w_result = w_cur ^ w_data;
      default:  w_result = w_data;
    endcase
  end

  assign w_ptr_nxt = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);

  // Idle cycles leave write_id/new_data untouched, so the file rewrites the same value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_write_id <= '0;
      r_new_data <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_write_id <= r_cnt;
          r_new_data <= '0;
          r_ack      <= '0;
          r_cnt      <= r_cnt + ID_W'(1);
          if (r_cnt == ID_W'(NUM_REGS - 1)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_ack <= '0;
          if (w_valid) begin
            r_write_id <= w_id;
            r_new_data <= w_result;
            r_ack      <= w_grant;
            r_ptr      <= w_ptr_nxt;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench: falling-edge register file model plus a transaction-level reference.
module tb_data_memory_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*IW-1:0]   req_id;
  logic [N*2-1:0]    req_op;
  logic [N*DW-1:0]   req_data;
  logic [DW-1:0]     reg1, reg2, reg3, reg4;
  logic [IW-1:0]     write_id;
  logic [DW-1:0]     new_data;
  logic [N-1:0]      ack;
  logic              busy;

  logic [DW-1:0]     rf [4];

  data_memory_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_id(req_id), .req_op(req_op),
    .req_data(req_data), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4),
    .write_id(write_id), .new_data(new_data), .ack(ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: no write enable, commits on every falling edge.
  always @(negedge clk) rf[write_id] <= new_data;
  assign reg1 = rf[0];
  assign reg2 = rf[1];
  assign reg3 = rf[2];
  assign reg4 = rf[3];

  int n_checks = 0;
  int n_errors = 0;

  bit t_req  [N];
  int t_id   [N];
  int t_op   [N];
  int t_data [N];

  int m_mem [4];
  int m_wid, m_wdata, m_ptr, m_cnt;
  bit m_run;
  int waits [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k]                  = t_req[k];
      req_id[k*IW +: IW]      = IW'(t_id[k]);
      req_op[k*2 +: 2]        = 2'(t_op[k]);
      req_data[k*DW +: DW]    = DW'(t_data[k]);
    end
  endtask

  task automatic set_req(input int k, input int id, input int op, input int data);
    t_req[k] = 1'b1; t_id[k] = id; t_op[k] = op; t_data[k] = data;
  endtask

  // One clock of the reference: choose the winner, predict outputs and the committed register.
  task automatic step(output int g);
    int eack, cur, res, k;
    eack = 0; g = -1; cur = 0; res = 0;
    if (m_run) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (g < 0 && t_req[k]) g = k;
      end
      if (g >= 0) begin
        cur = m_mem[t_id[g]];
        case (t_op[g])
          0:       res = t_data[g];
          1:       res = (cur + t_data[g]) % 256;
          2:       res = (cur - t_data[g] + 256) % 256;
          default: res = cur ^ t_data[g];
        endcase
        m_wid   = t_id[g];
        m_wdata = res;
        m_ptr   = (g + 1) % N;
        eack    = 1 << g;
      end
    end else begin
      m_wid   = m_cnt;
      m_wdata = 0;
      m_cnt++;
      if (m_cnt == 4) m_run = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("ack", 32'(ack), 32'(eack));
    check_eq("write_id", 32'(write_id), 32'(m_wid));
    check_eq("new_data", 32'(new_data), 32'(m_wdata));
    check_eq("busy", 32'(busy), 32'(!m_run));
    if (g >= 0) begin
      check_eq("rr_wait", 32'(waits[g] <= N - 1), 32'd1);
      for (int j = 0; j < N; j++) if (j != g && t_req[j]) waits[j]++;
      waits[g] = 0;
    end
    @(negedge clk); #1;
    m_mem[m_wid] = m_wdata;
    if (m_run) begin
      check_eq("reg1", 32'(reg1), 32'(m_mem[0]));
      check_eq("reg2", 32'(reg2), 32'(m_mem[1]));
      check_eq("reg3", 32'(reg3), 32'(m_mem[2]));
      check_eq("reg4", 32'(reg4), 32'(m_mem[3]));
    end
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) begin
      t_req[k] = 1'b0; waits[k] = 0;
    end
    drive();
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_write_id", 32'(write_id), 32'd0);
    check_eq("rst_new_data", 32'(new_data), 32'd0);
    clear_reqs();
    m_run = 1'b0; m_cnt = 0; m_ptr = 0; m_wid = 0; m_wdata = 0;
    @(negedge clk);
    @(negedge clk); #2 reset = 1'b1;
  endtask

  initial begin
    int g;
    int last [N];
    for (int k = 0; k < N; k++) begin
      t_id[k] = 0; t_op[k] = 0; t_data[k] = 0; t_req[k] = 1'b0; waits[k] = 0;
    end
    for (int r = 0; r < 4; r++) m_mem[r] = 0;
    drive();
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    do_reset();

    // INIT plus 20 idle cycles: outputs must sit at id 3 / 0x00.
    for (int i = 0; i < 24; i++) step(g);
    check_eq("idle_write_id", 32'(write_id), 32'd3);
    check_eq("idle_new_data", 32'(new_data), 32'd0);

    // Single WRITE to id 2.
    set_req(0, 2, 0, 8'hA5); drive();
    step(g);
    clear_reqs();
    step(g);
    check_eq("write_reg3", 32'(reg3), 32'hA5);

    // RMW wrap on id 0, back-to-back.
    set_req(1, 0, 0, 8'hF0); drive(); step(g);
    set_req(1, 0, 1, 8'h20); drive(); step(g);
    check_eq("add_wrap", 32'(reg1), 32'h10);
    set_req(1, 0, 2, 8'h11); drive(); step(g);
    check_eq("sub_wrap", 32'(reg1), 32'hFF);
    set_req(1, 0, 3, 8'h0F); drive(); step(g);
    check_eq("xor", 32'(reg1), 32'hF0);
    set_req(1, 0, 0, 8'h00); drive(); step(g);
    clear_reqs();

    // Fairness: everyone ADD 1 to id 0 for 8 cycles.
    for (int k = 0; k < N; k++) begin
      set_req(k, 0, 1, 1); last[k] = -100;
    end
    drive();
    for (int i = 0; i < 8; i++) begin
      step(g);
      check_eq("rr_grant_every_cycle", 32'(g >= 0), 32'd1);
      if (g >= 0) begin
        check_eq("rr_window", 32'(i - last[g] >= N), 32'd1);
        last[g] = i;
      end
    end
    clear_reqs();
    check_eq("rr_sum", 32'(reg1), 32'h08);

    // Idle no-op after a grant.
    set_req(0, 1, 0, 8'h3C); drive(); step(g);
    clear_reqs();
    for (int i = 0; i < 6; i++) step(g);
    check_eq("noop_write_id", 32'(write_id), 32'd1);
    check_eq("noop_new_data", 32'(new_data), 32'h3C);
    check_eq("noop_reg2", 32'(reg2), 32'h3C);

    // Reset while requester 2 has a transaction in flight and another pending.
    set_req(2, 3, 1, 8'h44); drive(); step(g);
    check_eq("pre_rst_ack", 32'(ack), 32'h4);
    set_req(2, 3, 1, 8'h55); drive();
    do_reset();
    for (int i = 0; i < 4; i++) step(g);
    check_eq("reinit_reg4", 32'(reg4), 32'd0);
    set_req(2, 3, 1, 8'h55); drive(); step(g);
    check_eq("post_rst_grant", 32'(g), 32'd2);
    clear_reqs();

    // Randomized traffic with holding requesters and re-requests.
    for (int i = 0; i < 400; i++) begin
      step(g);
      for (int k = 0; k < N; k++) begin
        if (t_req[k]) begin
          if (g == k) begin
            if ($urandom_range(1, 0) == 1)
              set_req(k, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(255, 0));
            else
              t_req[k] = 1'b0;
          end
        end else if ($urandom_range(9, 0) < 4) begin
          set_req(k, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(255, 0));
          waits[k] = 0;
        end
      end
      drive();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
